// File: rtl/nand_reduce_pipe_pkg.sv
// Shared definitions for the NAND/AND reduction pipeline.
//   - MODE_* : per-transaction operation encoding carried alongside the data
//   - *_MIN/*_MAX : legal parameter ranges
//   - tree_levels / stage_levels / stage_first : how the AND tree depth is
//     spread over the register stages
package nand_reduce_pipe_pkg;

  localparam logic MODE_NAND = 1'b0;
  localparam logic MODE_AND  = 1'b1;

  localparam int WIDTH_MIN  = 1;
  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // ceil(log2(n)) levels of 2-input AND
  function automatic int tree_levels(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << l) < n) l = l + 1;
    return l;
  endfunction

  // Levels evaluated in front of register s; leftovers go to the early stages
  function automatic int stage_levels(input int s, input int lv, input int stages);
    return lv / stages + ((s < lv % stages) ? 1 : 0);
  endfunction

  // First tree level evaluated in front of register s
  function automatic int stage_first(input int s, input int lv, input int stages);
    return s * (lv / stages) + ((s < lv % stages) ? s : lv % stages);
  endfunction

endpackage

// File: rtl/nand_pipe_stage.sv
// One elastic register stage with valid/ready handshake.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid/o_ready : upstream handshake (o_ready is combinational from i_ready)
//   i_data          : data to capture
//   o_valid/i_ready : downstream handshake
//   o_data          : registered data, held while stalled
module nand_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          w_load;

  // Load when empty or when the current entry leaves this cycle
  assign w_load  = ~r_valid | i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      // Bubbles leave the data untouched so the output never glitches
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/nand_reduce_pipe.sv
// Pipelined multi-operand NAND/AND reduction with valid/ready on both sides.
//   CLK, R              : clock, async active-low reset
//   A, MODE, VALID_IN   : operands (operand k at [k*WIDTH +: WIDTH]), op select
//   READY_IN            : transaction accepted when VALID_IN & READY_IN
//   Y, VALID_OUT        : registered result
//   READY_OUT           : result retired when VALID_OUT & READY_OUT
//   BUSY                : any stage holds valid data
module nand_reduce_pipe import nand_reduce_pipe_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    R,
  input  logic [NUM_IN*WIDTH-1:0] A,
  input  logic                    MODE,
  input  logic                    VALID_IN,
  output logic                    READY_IN,
  output logic [WIDTH-1:0]        Y,
  output logic                    VALID_OUT,
  input  logic                    READY_OUT,
  output logic                    BUSY
);

  localparam int LV = tree_levels(NUM_IN);
  localparam int NP = 1 << LV;           // operand count padded to a power of two
  localparam int OW = NP * WIDTH;
  localparam int DW = OW + 1;            // {mode, operands}

  if (WIDTH < WIDTH_MIN || NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
    $error("nand_reduce_pipe: illegal parameter set");
  end

  // Apply tree levels [first, first+nlev). After a level the surviving
  // partial products sit in the low slots; vacated slots are set to all-ones.
  function automatic logic [OW-1:0] tree_slice(input logic [OW-1:0] v,
                                               input int first, input int nlev);
    logic [OW-1:0] r;
    r = v;
    for (int lv = 0; lv < LV; lv++) begin
      if (lv >= first && lv < first + nlev) begin
        for (int k = 0; k < NP / 2; k++)
          if (k < (NP >> (lv + 1)))
            r[k*WIDTH +: WIDTH] = r[2*k*WIDTH +: WIDTH] & r[(2*k+1)*WIDTH +: WIDTH];
        for (int k = 0; k < NP; k++)
          if (k >= (NP >> (lv + 1)))
            r[k*WIDTH +: WIDTH] = '1;
      end
    end
    return r;
  endfunction

  // Remaining levels plus the optional inversion in front of the output register
  function automatic logic [WIDTH-1:0] final_slice(input logic [OW-1:0] v,
                                                   input int first, input int nlev,
                                                   input logic mode);
    logic [OW-1:0] t;
    t = tree_slice(v, first, nlev);
    return t[WIDTH-1:0] ^ {WIDTH{mode == MODE_NAND}};
  endfunction

  logic [STAGES:0]            w_vld;   // [0] = VALID_IN, [s+1] = stage s valid
  logic [STAGES:0]            w_rdy;   // [s] = stage s ready, [STAGES] = READY_OUT
  logic [STAGES-1:0][DW-1:0]  w_q;     // [0] = input word, [s] = stage s-1 data
  logic [OW-1:0]              w_pad;
  logic [WIDTH-1:0]           w_y;

  // Padding operands are all-ones, the identity of AND
  always_comb begin
    w_pad = '1;
    w_pad[NUM_IN*WIDTH-1:0] = A;
  end

  assign w_q[0]        = {MODE, w_pad};
  assign w_vld[0]      = VALID_IN;
  assign w_rdy[STAGES] = READY_OUT;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int FIRST = stage_first(s, LV, STAGES);
    localparam int NLEV  = stage_levels(s, LV, STAGES);
    if (s < STAGES - 1) begin : g_mid
      logic [DW-1:0] w_d;
      assign w_d = {w_q[s][OW], tree_slice(w_q[s][OW-1:0], FIRST, NLEV)};
      nand_pipe_stage #(.DW(DW)) u_stage (
        .i_clk   (CLK),
        .i_rst_n (R),
        .i_valid (w_vld[s]),
        .o_ready (w_rdy[s]),
        .i_data  (w_d),
        .o_valid (w_vld[s+1]),
        .o_data  (w_q[s+1]),
        .i_ready (w_rdy[s+1])
      );
    end else begin : g_last
      // Output stage keeps only the result; mode is consumed here
      logic [WIDTH-1:0] w_d;
      assign w_d = final_slice(w_q[s][OW-1:0], FIRST, NLEV, w_q[s][OW]);
      nand_pipe_stage #(.DW(WIDTH)) u_stage (
        .i_clk   (CLK),
        .i_rst_n (R),
        .i_valid (w_vld[s]),
        .o_ready (w_rdy[s]),
        .i_data  (w_d),
        .o_valid (w_vld[s+1]),
        .o_data  (w_y),
        .i_ready (w_rdy[s+1])
      );
    end
  end

  assign READY_IN  = w_rdy[0];
  assign VALID_OUT = w_vld[STAGES];
  assign Y         = w_y;
  assign BUSY      = |w_vld[STAGES:1];

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, pipelined successor to the single-bit 2-input NAND cell for the SoC flow datapath library.
- Performs a bitwise NAND (or AND, selectable per transaction) across NUM_IN input words of WIDTH bits.
- The result passes through an elastic register pipeline with valid/ready handshake on both sides.
- Sits between operand producers and consumers where a wide, multi-operand NAND reduction must meet timing and tolerate backpressure.

Parameters:
- WIDTH, 8, bit width of each operand and of the result (>=1).
- NUM_IN, 2, number of operands reduced (2..16).
- STAGES, 2, register stages between input and output (1..4); sets the latency.

Ports:
- CLK  input  1  rising-edge clock.
- R  input  1  asynchronous active-low reset.
- A  input  NUM_IN*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- MODE  input  1  0 = NAND reduction, 1 = AND reduction; sampled with A.
- VALID_IN  input  1  upstream has a transaction on A/MODE.
- READY_IN  output  1  block accepts a transaction this cycle.
- Y  output  WIDTH  reduction result.
- VALID_OUT  output  1  Y holds a valid result.
- READY_OUT  input  1  downstream accepts Y this cycle.
- BUSY  output  1  at least one stage holds valid data.

Behaviour:
- Function: Y[b] = ~(A0[b] & A1[b] & ... & A(NUM_IN-1)[b]) when MODE=0; the same product without the inversion when MODE=1.
- MODE travels with its own data; it is never a global setting.
- Reduction tree: ceil(log2 NUM_IN) levels of 2-input AND, split as evenly as possible across the STAGES registers. The final inversion is applied in the last stage.
- Pipeline: STAGES stages, each holding a valid bit, data, and MODE.
- Latency: an input accepted at edge t appears on Y/VALID_OUT after edge t+STAGES-1, i.e. visible in cycle t+STAGES. This holds when the pipeline is unstalled.
- Acceptance: a transfer occurs on an edge where VALID_IN & READY_IN. Output retires on an edge where VALID_OUT & READY_OUT.
- Stage i loads from stage i-1 when stage i is empty or stage i is itself advancing. A stage that is not loading holds its contents, and its valid bit clears when it advances.
- READY_IN = ~v0 | adv0, where adv0 means stage 0 moves forward this cycle. The ready path is combinational from READY_OUT, so full throughput is one transaction per cycle.
- Backpressure: with READY_OUT=0 and VALID_OUT=1, Y and VALID_OUT must be held stable. The pipeline fills to exactly STAGES entries, then READY_IN=0.
- No data is dropped or duplicated.
- Simultaneous accept and retire with a full pipeline: both occur on the same edge and the occupancy stays constant.
- VALID_IN=1 while READY_IN=0: the upstream holds, and the block does not sample.
- BUSY = OR of all stage valid bits.
- Reset (R low, asynchronous, at any time including mid-stream):
  - All valid bits go to 0, which drives VALID_OUT=0 and BUSY=0.
  - Y is reset to 0.
  - READY_IN becomes 1 once R is high.
  - In-flight transactions are discarded.
  - Deassertion is synchronised by the integrator.
- Y is a registered output with no combinational path from A.

Decomposition:
- Shared package:
  - mode encoding constants (MODE_NAND=0, MODE_AND=1);
  - the function that computes per-stage tree levels from NUM_IN and STAGES;
  - the parameter legality limits.
- Sub-module nand_pipe_stage: one elastic register stage with valid/ready, data and mode. It is instantiated STAGES times, with the tree slices placed in between.

Test Plan:
- WIDTH=8, NUM_IN=2, STAGES=2, MODE=0, A0=8'hF0, A1=8'hCC, READY_OUT=1. Expected: Y=8'h3F with VALID_OUT high exactly 2 cycles after acceptance.
- NUM_IN=4, MODE=1, operands FF/FF/0F/F5. Expected: Y=8'h05. Same operands with MODE=0: Y=8'hFA. Back-to-back transactions with alternating MODE each return the correct per-transaction mode.
- Stream of 10 random transactions with READY_OUT=0 for 5 cycles mid-stream:
  - READY_IN drops after STAGES entries are held;
  - Y stays stable while stalled;
  - all 10 results arrive in order with none lost.
- Full pipeline with VALID_IN=1 and READY_OUT=1 continuously. Expected: one result per cycle, READY_IN held at 1, occupancy constant.
- Assert R low while 2 transactions are in flight. Expected: VALID_OUT=0, BUSY=0, Y=0 immediately with no clock edge. After release, a new transaction 8'hAA NAND 8'hFF gives Y=8'h55 at the nominal latency.
- NUM_IN=16, STAGES=4, all operands 8'hFF except operand 15 = 8'h7F. Expected: Y=8'h80, latency 4.
